chrono_ctrl: RTL and testbench
==============================

Name: chrono_ctrl

Overview:
- Run/stop/lap/clear sequencer for the chronometer counter datapath.
- Consumes the two debounced button levels (active-low, idle high) and decodes press events.
- Runs a four-state control FSM and generates the gated TICK_HZ count-enable pulse.
- Drives the clear and display-freeze controls of the BCD counter/display path.

Parameters:
- CLK_HZ, 50_000_000, system clock frequency in Hz.
- TICK_HZ, 100, count tick rate in Hz (centiseconds). DIV = CLK_HZ/TICK_HZ; DIV >= 2 is required and is elaboration-checked.

Ports:
- clk  in  1  system clock; all logic on posedge.
- rst  in  1  synchronous reset, active-high.
- btn_start_n  in  1  debounced start/stop button, active-low, synchronous to clk.
- btn_lap_n  in  1  debounced lap/clear button, active-low, synchronous to clk.
- tick  out  1  one-cycle count enable to the counter, at TICK_HZ while counting.
- clr  out  1  one-cycle synchronous clear to the counter and the lap latch.
- freeze  out  1  level; display holds its latched value while high.
- running  out  1  level; high in RUN or LAP.
- state  out  2  FSM state: 0=IDLE, 1=RUN, 2=STOP, 3=LAP.

Behaviour:
- Reset (rst=1 at a clk edge): state=IDLE, tick=0, clr=0, freeze=0, running=0, div_cnt=0. Both button history registers are set to 1. Reset wins over every other event, including in mid-count or in LAP.
- Press detect: a press is history=1 and current input=0. A press is acted on at the same edge where the low level is first sampled; history then updates to the input.
  - A button held through reset release generates no press.
  - One event per falling edge; holding a button does not repeat.
- Simultaneous start and lap press in one cycle: start is processed, lap is discarded.
- FSM transitions (all outputs registered, visible the cycle after the deciding edge):
  - IDLE: start -> RUN; lap ignored.
  - RUN: start -> STOP; lap -> LAP.
  - LAP: lap -> RUN (unfreeze); start -> STOP (unfreeze).
  - STOP: start -> RUN (resume); lap -> IDLE with clr=1 for exactly one cycle.
- freeze = (state==LAP). running = (state==RUN or LAP).
- Prescaler div_cnt, width clog2(DIV):
  - In RUN/LAP: increments every cycle and wraps DIV-1 -> 0. Wrap sets tick=1 for one cycle.
  - In STOP: div_cnt holds, so resume keeps the fractional period.
  - In IDLE or on clr: div_cnt = 0.
- Tick timing:
  - First tick after IDLE->RUN is high in the cycle after the DIV-th edge following the start edge. Steady-state spacing is exactly DIV cycles.
  - Ticks are unaffected by RUN<->LAP transitions.
  - No tick while in STOP or IDLE, including the cycle after leaving RUN.
- clr is never asserted together with tick.

Test Plan:
- CLK_HZ=1000, TICK_HZ=100 (DIV=10); hold rst 3 cycles with btn_start_n=0 -> all outputs 0, state=0. Release rst -> no transition while the button stays low.
- Start press from IDLE -> state=1 and running=1 next cycle. tick first high 10 cycles after the start edge, then every 10 cycles; 5 ticks in 50 cycles.
- Stop at div_cnt=4, wait 37 cycles, resume -> no ticks while stopped. First tick after resume comes 6 cycles after the resume edge.
- Lap press in RUN -> freeze=1, state=3, ticks continue every 10 cycles. Second lap press -> freeze=0, state=1.
- Stop, then lap press -> state=0 and clr high exactly one cycle. div_cnt=0 on the next start (first tick 10 cycles later).
- Start and lap pressed on the same edge in RUN -> state=2 (STOP), freeze stays 0. Assert rst while in LAP -> state=0, freeze=0, tick=0 next cycle.

Source files
------------

// File: rtl/chrono_ctrl.sv
// -----------------------------------------------------------------------------
// chrono_ctrl
// Run/stop/lap/clear sequencer for the chronometer counter datapath.
// Decodes press events from two debounced active-low buttons, runs the
// IDLE/RUN/STOP/LAP control FSM and generates the gated count-enable tick.
//
// Ports
//   clk          system clock, all logic on the rising edge
//   rst          synchronous reset, active-high
//   btn_start_n  debounced start/stop button, active-low
//   btn_lap_n    debounced lap/clear button, active-low
//   tick         one-cycle count enable at TICK_HZ while counting
//   clr          one-cycle clear to the counter and lap latch
//   freeze       display holds its latched value while high (LAP)
//   running      high in RUN or LAP
//   state        FSM state: 0=IDLE, 1=RUN, 2=STOP, 3=LAP
// -----------------------------------------------------------------------------
module chrono_ctrl #(
    parameter int CLK_HZ  = 50_000_000,
    parameter int TICK_HZ = 100
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_start_n,
    input  logic       btn_lap_n,
    output logic       tick,
    output logic       clr,
    output logic       freeze,
    output logic       running,
    output logic [1:0] state
);

    localparam int DIV = CLK_HZ / TICK_HZ;
    localparam int CW  = (DIV < 2) ? 1 : $clog2(DIV);
    localparam logic [CW-1:0] DIV_MAX = CW'(DIV - 1);

    // A divider below 2 cannot produce a one-cycle tick pulse.
    if (DIV < 2) begin : g_div_check
        $error("chrono_ctrl: CLK_HZ/TICK_HZ must be at least 2");
    end

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_STOP = 2'd2,
        ST_LAP  = 2'd3
    } state_t;

    state_t        state_r;
    state_t        state_nxt_s;
    logic [CW-1:0] div_cnt_r;
    logic [CW-1:0] div_nxt_s;
    logic          tick_r;
    logic          tick_nxt_s;
    logic          clr_r;
    logic          clr_nxt_s;
    logic          freeze_r;
    logic          running_r;
    logic          start_hist_r;
    logic          lap_hist_r;
    logic          primed_r;
    logic          start_press_s;
    logic          lap_press_s;
    logic          count_s;

    // Press decode, FSM next state and prescaler next value.
    always_comb begin
        state_nxt_s = state_r;
        clr_nxt_s   = 1'b0;
        div_nxt_s   = div_cnt_r;
        tick_nxt_s  = 1'b0;
        count_s     = 1'b0;

        // primed_r masks the first edge after reset so a button held through
        // reset release is absorbed into history instead of becoming a press.
        start_press_s = primed_r & start_hist_r & ~btn_start_n;
        lap_press_s   = primed_r & lap_hist_r & ~btn_lap_n;

        // Start has priority: a simultaneous lap press is discarded.
        case (state_r)
            ST_IDLE: begin
                if (start_press_s) begin
                    state_nxt_s = ST_RUN;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (start_press_s) begin
                    state_nxt_s = ST_STOP;
                end else if (lap_press_s) begin
                    state_nxt_s = ST_LAP;
                end else begin
                    state_nxt_s = ST_RUN;
                end
            end
            ST_LAP: begin
                if (start_press_s) begin
                    state_nxt_s = ST_STOP;
                end else if (lap_press_s) begin
                    state_nxt_s = ST_RUN;
                end else begin
                    state_nxt_s = ST_LAP;
                end
            end
            ST_STOP: begin
                if (start_press_s) begin
                    state_nxt_s = ST_RUN;
                end else if (lap_press_s) begin
                    state_nxt_s = ST_IDLE;
                    clr_nxt_s   = 1'b1;
                end else begin
                    state_nxt_s = ST_STOP;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase

        // Count only on edges that both start and end in a counting state:
        // the start edge leaves the phase at zero and the stop edge freezes
        // it, so no tick can appear in the cycle after leaving RUN/LAP.
        count_s = ((state_r == ST_RUN) || (state_r == ST_LAP)) &&
                  ((state_nxt_s == ST_RUN) || (state_nxt_s == ST_LAP));

        if (clr_nxt_s || (state_nxt_s == ST_IDLE)) begin
            div_nxt_s  = '0;
            tick_nxt_s = 1'b0;
        end else if (count_s) begin
            if (div_cnt_r == DIV_MAX) begin
                div_nxt_s  = '0;
                tick_nxt_s = 1'b1;
            end else begin
                div_nxt_s  = div_cnt_r + CW'(1);
                tick_nxt_s = 1'b0;
            end
        end else begin
            div_nxt_s  = div_cnt_r;
            tick_nxt_s = 1'b0;
        end
    end

    // State, prescaler, button history and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= ST_IDLE;
            div_cnt_r    <= '0;
            tick_r       <= 1'b0;
            clr_r        <= 1'b0;
            freeze_r     <= 1'b0;
            running_r    <= 1'b0;
            start_hist_r <= 1'b1;
            lap_hist_r   <= 1'b1;
            primed_r     <= 1'b0;
        end else begin
            state_r      <= state_nxt_s;
            div_cnt_r    <= div_nxt_s;
            tick_r       <= tick_nxt_s;
            clr_r        <= clr_nxt_s;
            freeze_r     <= (state_nxt_s == ST_LAP);
            running_r    <= (state_nxt_s == ST_RUN) || (state_nxt_s == ST_LAP);
            start_hist_r <= btn_start_n;
            lap_hist_r   <= btn_lap_n;
            primed_r     <= 1'b1;
        end
    end

    assign tick    = tick_r;
    assign clr     = clr_r;
    assign freeze  = freeze_r;
    assign running = running_r;
    assign state   = state_r;

endmodule

// File: tb/tb_chrono_ctrl.sv
// -----------------------------------------------------------------------------
// tb_chrono_ctrl
// Directed self-checking bench for chrono_ctrl with CLK_HZ=1000, TICK_HZ=100
// (DIV=10). Inputs change just after the falling edge; outputs are sampled at
// the falling edge, so each cyc() shows the effect of exactly one rising edge.
// -----------------------------------------------------------------------------
module tb_chrono_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       btn_start_n = 1'b1;
    logic       btn_lap_n = 1'b1;
    logic       tick;
    logic       clr;
    logic       freeze;
    logic       running;
    logic [1:0] state;

    int n_checks = 0;
    int n_fail   = 0;

    chrono_ctrl #(.CLK_HZ(1000), .TICK_HZ(100)) dut (
        .clk         (clk),
        .rst         (rst),
        .btn_start_n (btn_start_n),
        .btn_lap_n   (btn_lap_n),
        .tick        (tick),
        .clr         (clr),
        .freeze      (freeze),
        .running     (running),
        .state       (state)
    );

    always #5 clk = ~clk;

    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        btn_start_n = 1'b0;
        repeat (3) cyc();
        n_checks++;
        if ({state, tick, clr, freeze, running} !== 6'b00_0000) begin
            n_fail++;
            $display("FAIL reset_outputs got state=%0d tick=%b clr=%b freeze=%b running=%b exp all 0",
                     state, tick, clr, freeze, running);
        end
        rst = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            cyc();
            n_checks++;
            if ({state, running} !== 3'b00_0) begin
                n_fail++;
                $display("FAIL held_thru_reset cyc %0d got state=%0d running=%b exp 0 0", k, state, running);
            end
        end
        btn_start_n = 1'b1;
        cyc();
    endtask

    task automatic test_start_ticks();
        int ticks;
        ticks = 0;
        btn_start_n = 1'b0;
        cyc();
        n_checks++;
        if ({state, running, tick} !== 4'b01_1_0) begin
            n_fail++;
            $display("FAIL start_edge got state=%0d running=%b tick=%b exp 1 1 0", state, running, tick);
        end
        // Holding the button for a few cycles must not produce a second event.
        for (int k = 1; k <= 50; k++) begin
            if (k == 4) btn_start_n = 1'b1;
            cyc();
            if (tick === 1'b1) ticks++;
            n_checks++;
            if (tick !== ((k % 10) == 0)) begin
                n_fail++;
                $display("FAIL run_tick k=%0d got %b exp %b", k, tick, ((k % 10) == 0));
            end
        end
        n_checks++;
        if (ticks != 5 || state !== 2'd1) begin
            n_fail++;
            $display("FAIL run_tick_count got %0d state=%0d exp 5 state=1", ticks, state);
        end
    endtask

    task automatic test_stop_resume();
        int ticks;
        ticks = 0;
        repeat (4) cyc();            // phase now 4
        btn_start_n = 1'b0;
        cyc();
        btn_start_n = 1'b1;
        n_checks++;
        if ({state, running, tick} !== 4'b10_0_0) begin
            n_fail++;
            $display("FAIL stop_edge got state=%0d running=%b tick=%b exp 2 0 0", state, running, tick);
        end
        for (int k = 1; k <= 37; k++) begin
            cyc();
            if (tick !== 1'b0 || state !== 2'd2) ticks++;
        end
        n_checks++;
        if (ticks != 0) begin
            n_fail++;
            $display("FAIL stopped_quiet got %0d bad cycles exp 0", ticks);
        end
        btn_start_n = 1'b0;
        cyc();
        btn_start_n = 1'b1;
        n_checks++;
        if ({state, running, tick} !== 4'b01_1_0) begin
            n_fail++;
            $display("FAIL resume_edge got state=%0d running=%b tick=%b exp 1 1 0", state, running, tick);
        end
        for (int k = 1; k <= 6; k++) begin
            cyc();
            n_checks++;
            if (tick !== (k == 6)) begin
                n_fail++;
                $display("FAIL resume_tick k=%0d got %b exp %b", k, tick, (k == 6));
            end
        end
    endtask

    task automatic test_lap();
        btn_lap_n = 1'b0;
        cyc();
        btn_lap_n = 1'b1;
        n_checks++;
        if ({state, freeze, running, tick} !== 5'b11_1_1_0) begin
            n_fail++;
            $display("FAIL lap_enter got state=%0d freeze=%b running=%b tick=%b exp 3 1 1 0",
                     state, freeze, running, tick);
        end
        // Phase went 0->1 on the lap edge, so ticks follow 9 and 19 edges later.
        for (int k = 1; k <= 20; k++) begin
            cyc();
            n_checks++;
            if (tick !== (k == 9 || k == 19)) begin
                n_fail++;
                $display("FAIL lap_tick k=%0d got %b exp %b", k, tick, (k == 9 || k == 19));
            end
        end
        btn_lap_n = 1'b0;
        cyc();
        btn_lap_n = 1'b1;
        n_checks++;
        if ({state, freeze, running} !== 4'b01_0_1) begin
            n_fail++;
            $display("FAIL lap_exit got state=%0d freeze=%b running=%b exp 1 0 1", state, freeze, running);
        end
    endtask

    task automatic test_clear();
        btn_start_n = 1'b0;
        cyc();
        btn_start_n = 1'b1;
        cyc();
        n_checks++;
        if (state !== 2'd2) begin
            n_fail++;
            $display("FAIL clear_stop got state=%0d exp 2", state);
        end
        btn_lap_n = 1'b0;
        cyc();
        btn_lap_n = 1'b1;
        n_checks++;
        if ({state, clr, tick, freeze, running} !== 6'b00_1_0_0_0) begin
            n_fail++;
            $display("FAIL clear_edge got state=%0d clr=%b tick=%b freeze=%b running=%b exp 0 1 0 0 0",
                     state, clr, tick, freeze, running);
        end
        cyc();
        n_checks++;
        if ({state, clr} !== 3'b00_0) begin
            n_fail++;
            $display("FAIL clear_one_cycle got state=%0d clr=%b exp 0 0", state, clr);
        end
        btn_start_n = 1'b0;
        cyc();
        btn_start_n = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            cyc();
            n_checks++;
            if (tick !== (k == 10) || clr !== 1'b0) begin
                n_fail++;
                $display("FAIL clear_restart k=%0d got tick=%b clr=%b exp %b 0", k, tick, clr, (k == 10));
            end
        end
    endtask

    task automatic test_simultaneous();
        btn_start_n = 1'b0;
        btn_lap_n   = 1'b0;
        cyc();
        btn_start_n = 1'b1;
        btn_lap_n   = 1'b1;
        n_checks++;
        if ({state, freeze, running} !== 4'b10_0_0) begin
            n_fail++;
            $display("FAIL simul_press got state=%0d freeze=%b running=%b exp 2 0 0", state, freeze, running);
        end
        repeat (3) cyc();
        n_checks++;
        if ({state, clr} !== 3'b10_0) begin
            n_fail++;
            $display("FAIL simul_lap_dropped got state=%0d clr=%b exp 2 0", state, clr);
        end
    endtask

    task automatic test_reset_in_lap();
        btn_start_n = 1'b0;
        cyc();
        btn_start_n = 1'b1;
        cyc();
        btn_lap_n = 1'b0;
        cyc();
        btn_lap_n = 1'b1;
        n_checks++;
        if ({state, freeze} !== 3'b11_1) begin
            n_fail++;
            $display("FAIL pre_reset_lap got state=%0d freeze=%b exp 3 1", state, freeze);
        end
        repeat (5) cyc();
        rst = 1'b1;
        cyc();
        n_checks++;
        if ({state, freeze, tick, running, clr} !== 6'b00_0_0_0_0) begin
            n_fail++;
            $display("FAIL reset_in_lap got state=%0d freeze=%b tick=%b running=%b clr=%b exp all 0",
                     state, freeze, tick, running, clr);
        end
        rst = 1'b0;
        repeat (12) cyc();
        n_checks++;
        if ({state, tick} !== 3'b00_0) begin
            n_fail++;
            $display("FAIL post_reset_idle got state=%0d tick=%b exp 0 0", state, tick);
        end
    endtask

    initial begin
        test_reset();
        test_start_ticks();
        test_stop_resume();
        test_lap();
        test_clear();
        test_simultaneous();
        test_reset_in_lap();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
